bus_source_arbiter: RTL and testbench
=====================================

BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 25, meaning the number of bus source out-enable lines (legal range 2..32).
REQ-002 The block SHALL have parameter SEL_W, default 5, meaning the select width; SEL_W SHALL be at least ceil(log2(NUM_SRC)).
REQ-003 The block SHALL have parameter RR_MODE, default 0, meaning 0 selects fixed priority and 1 selects round-robin.
REQ-004 The block SHALL have parameter IDLE_SEL, default 0, meaning the select value driven when no source requests.
REQ-005 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 clear  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 src_out  input  NUM_SRC  SHALL carry the out-enable strobes, with bit i requesting source index i.
REQ-008 hold  input  1  SHALL freeze the arbiter when high.
REQ-009 clr_conflict  input  1  SHALL be a synchronous clear of conflict_sticky.
REQ-010 select  output  SEL_W  SHALL carry the registered index of the granted source.
REQ-011 select_valid  output  1  SHALL be high when select reflects a real grant.
REQ-012 conflict  output  1  SHALL be high when more than one src_out bit was high in the sampled cycle.
REQ-013 conflict_sticky  output  1  SHALL be a latched OR of conflict.

Function
REQ-014 select, select_valid and conflict SHALL have one clock of latency: sampled src_out at edge N appears after edge N.
REQ-015 With RR_MODE=0 and hold low, the lowest-index asserted src_out bit SHALL win.
REQ-016 With RR_MODE=1, the search SHALL start at pointer rr_ptr and ascend modulo NUM_SRC; the first asserted bit SHALL win.
REQ-017 After a round-robin grant of index i, rr_ptr SHALL become i+1, wrapping to 0 when i = NUM_SRC-1.
REQ-018 rr_ptr SHALL be unchanged on cycles with no request or with hold high.
REQ-019 With no src_out bit high and hold low, select SHALL load IDLE_SEL and select_valid SHALL load 0.
REQ-020 conflict SHALL load 1 iff two or more src_out bits are high, and SHALL load 0 otherwise.
REQ-021 With hold high, select, select_valid, conflict and rr_ptr SHALL retain their values, and src_out SHALL be ignored.
REQ-022 conflict_sticky SHALL set on any cycle in which conflict loads 1, and SHALL clear on clr_conflict.
REQ-023 When set and clr_conflict occur in the same cycle, set SHALL win.
REQ-024 clr_conflict SHALL act regardless of hold.
REQ-025 src_out bits at index NUM_SRC and above SHALL not exist, and select SHALL never exceed NUM_SRC-1 except for IDLE_SEL.

Reset
REQ-026 While clear is low, select SHALL be IDLE_SEL, and select_valid, conflict, conflict_sticky and rr_ptr SHALL be 0, independent of clock.
REQ-027 Reset asserted mid-operation SHALL abort any grant.
REQ-028 The first edge after clear rises SHALL sample src_out normally.

Configuration
REQ-029 With macro BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN defined, the block SHALL add output conflict_count (8 bits).
REQ-030 conflict_count SHALL increment on each cycle conflict loads 1, saturate at 255, and return to 0 on reset or clr_conflict.
REQ-031 Without BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN, the port and its counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario 1 (reset): clear low with src_out=0x0000010 and clocks running -> select=0, select_valid=0, conflict_sticky=0.
REQ-033 Scenario 2 (fixed priority): RR_MODE=0, src_out bits 3 and 21 high -> after 1 edge, select=3, select_valid=1, conflict=1, conflict_sticky=1.
REQ-034 Scenario 3 (round-robin rotation): RR_MODE=1, bits 3 and 21 held high -> select sequence 3, 21, 3, 21.
REQ-035 Scenario 4 (round-robin wrap): RR_MODE=1, bit 24 then bit 0 -> select 24 then 0, and rr_ptr wraps to 0 after granting 24.
REQ-036 Scenario 5 (hold and idle): hold high with new src_out -> outputs unchanged; hold low with src_out=0 -> select=0, select_valid=0.
REQ-037 Scenario 6 (sticky priority and counter): clr_conflict coincident with a conflict -> conflict_sticky stays 1; with the macro defined, 300 conflict cycles -> conflict_count=255.

Source files
------------

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: grants one of NUM_SRC bus source out-enable strobes per
// clock, by either fixed priority or round-robin. The grant index, a valid
// flag and a multi-request conflict flag are all registered. A sticky copy of
// the conflict flag is also kept.
// Optional feature: define BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN to add an
// 8-bit saturating conflict_count output.
//
// Handshake note: there is no valid/ready pair here. src_out is sampled on
// every rising edge unless hold is high. select_valid qualifies select for the
// cycle that follows that edge.
module bus_source_arbiter #(
    parameter int NUM_SRC  = 25,
    parameter int SEL_W    = 5,
    parameter int RR_MODE  = 0,
    parameter int IDLE_SEL = 0
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] src_out,
    input  logic               hold,
    input  logic               clr_conflict,
    output logic [SEL_W-1:0]   select,
    output logic               select_valid,
    output logic               conflict,
`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
    output logic [7:0]         conflict_count,
`endif
    output logic               conflict_sticky
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_found;
    logic             multi_req;
    logic [SEL_W-1:0] ptr_next;
    int               rr_idx;

    // Pick the winning index. The loops descend, so the smallest qualifying
    // position is the last one written and therefore wins.
    always_comb begin
        grant_idx   = SEL_W'(IDLE_SEL);
        grant_found = 1'b0;
        rr_idx      = 0;
        if (RR_MODE == 0) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (src_out[IDX_W'(i)]) begin
                    grant_idx   = SEL_W'(i);
                    grant_found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                rr_idx = (int'(rr_ptr) + k) % NUM_SRC;
                if (src_out[IDX_W'(rr_idx)]) begin
                    grant_idx   = SEL_W'(rr_idx);
                    grant_found = 1'b1;
                end
            end
        end
    end

    // Two or more bits are set exactly when clearing the lowest set bit leaves
    // something behind.
    always_comb begin
        multi_req = |(src_out & (src_out - NUM_SRC'(1)));
    end

    // The next round-robin start is one past the grant, wrapping at the top.
    always_comb begin
        ptr_next = '0;
        if (grant_idx != SEL_W'(NUM_SRC - 1)) begin
            ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // Grant registers. hold freezes the grant, the conflict flag and the pointer.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            select       <= SEL_W'(IDLE_SEL);
            select_valid <= 1'b0;
            conflict     <= 1'b0;
            rr_ptr       <= '0;
        end else if (!hold) begin
            select       <= grant_idx;
            select_valid <= grant_found;
            conflict     <= multi_req;
            if ((RR_MODE != 0) && grant_found) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    // Sticky conflict. A new conflict outranks a coincident clear. The clear
    // still acts while the block is held.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            conflict_sticky <= 1'b0;
        end else if (!hold && multi_req) begin
            conflict_sticky <= 1'b1;
        end else if (clr_conflict) begin
            conflict_sticky <= 1'b0;
        end
    end

`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
    // Saturating count of conflict cycles. When a clear meets a new conflict,
    // the count restarts at that conflict.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            conflict_count <= 8'd0;
        end else if (clr_conflict) begin
            conflict_count <= (!hold && multi_req) ? 8'd1 : 8'd0;
        end else if (!hold && multi_req && (conflict_count != 8'hFF)) begin
            conflict_count <= conflict_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Testbench for bus_source_arbiter. Two instances share one set of inputs:
// u_fp runs fixed priority and u_rr runs round-robin.
// The conflict_count checks are active when BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
// is defined.
module tb_bus_source_arbiter;

    localparam int NUM_SRC = 25;
    localparam int SEL_W   = 5;

    logic               clock = 1'b0;
    logic               clear;
    logic               hold;
    logic               clr_conflict;
    logic [NUM_SRC-1:0] src_out;

    logic [SEL_W-1:0] fp_select, rr_select;
    logic             fp_valid, rr_valid;
    logic             fp_conflict, rr_conflict;
    logic             fp_sticky, rr_sticky;
`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
    logic [7:0]       fp_count, rr_count;
`endif

    int checks   = 0;
    int failures = 0;

    // clock/reset block
    always #5 clock = ~clock;

    bus_source_arbiter #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RR_MODE(0), .IDLE_SEL(0)) u_fp (
        .clock           (clock),
        .clear           (clear),
        .src_out         (src_out),
        .hold            (hold),
        .clr_conflict    (clr_conflict),
        .select          (fp_select),
        .select_valid    (fp_valid),
        .conflict        (fp_conflict),
`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
        .conflict_count  (fp_count),
`endif
        .conflict_sticky (fp_sticky)
    );

    bus_source_arbiter #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RR_MODE(1), .IDLE_SEL(0)) u_rr (
        .clock           (clock),
        .clear           (clear),
        .src_out         (src_out),
        .hold            (hold),
        .clr_conflict    (clr_conflict),
        .select          (rr_select),
        .select_valid    (rr_valid),
        .conflict        (rr_conflict),
`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
        .conflict_count  (rr_count),
`endif
        .conflict_sticky (rr_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_fp(input string tag, input int sel, input int vld, input int con, input int stk);
        check({tag, " fp select"},   32'(fp_select),   32'(sel));
        check({tag, " fp valid"},    32'(fp_valid),    32'(vld));
        check({tag, " fp conflict"}, 32'(fp_conflict), 32'(con));
        check({tag, " fp sticky"},   32'(fp_sticky),   32'(stk));
    endtask

    task automatic expect_rr(input string tag, input int sel, input int vld, input int ptr);
        check({tag, " rr select"}, 32'(rr_select),    32'(sel));
        check({tag, " rr valid"},  32'(rr_valid),     32'(vld));
        check({tag, " rr ptr"},    32'(u_rr.rr_ptr),  32'(ptr));
    endtask

    // driver and directed vectors
    initial begin
        clear        = 1'b0;
        hold         = 1'b0;
        clr_conflict = 1'b0;
        src_out      = 25'h0000010;

        // Scenario 1: reset holds the outputs while the clock runs.
        step(3);
        expect_fp("reset", 0, 0, 0, 0);
        expect_rr("reset", 0, 0, 0);
        check("reset rr sticky", 32'(rr_sticky), 32'd0);

        // Scenario 2: fixed priority picks bit 3 over bit 21.
        clear   = 1'b1;
        src_out = (25'd1 << 3) | (25'd1 << 21);
        step(1);
        expect_fp("prio e1", 3, 1, 1, 1);
        // Scenario 3: round-robin alternates 3, 21, 3, 21.
        expect_rr("rot e1", 3, 1, 4);
        check("rot conflict", 32'(rr_conflict), 32'd1);
        step(1);
        expect_rr("rot e2", 21, 1, 22);
        check("prio e2 fp select", 32'(fp_select), 32'd3);
        step(1);
        expect_rr("rot e3", 3, 1, 4);
        step(1);
        expect_rr("rot e4", 21, 1, 22);

        // Scenario 4: a grant of bit 24 wraps the pointer to 0, then bit 0 is granted.
        src_out = 25'd1 << 24;
        step(1);
        expect_fp("wrap e1", 24, 1, 0, 1);
        expect_rr("wrap e1", 24, 1, 0);
        src_out = 25'd1;
        step(1);
        expect_fp("wrap e2", 0, 1, 0, 1);
        expect_rr("wrap e2", 0, 1, 1);

        // clr_conflict acts while held, and the held conflicting input does not set sticky.
        hold         = 1'b1;
        clr_conflict = 1'b1;
        src_out      = (25'd1 << 7) | (25'd1 << 9);
        step(1);
        // Scenario 5: hold freezes select, valid, conflict and the pointer.
        expect_fp("hold", 0, 1, 0, 0);
        expect_rr("hold", 0, 1, 1);
        clr_conflict = 1'b0;
        step(1);
        expect_fp("hold2", 0, 1, 0, 0);
        hold    = 1'b0;
        src_out = '0;
        step(1);
        expect_fp("idle", 0, 0, 0, 0);
        expect_rr("idle", 0, 0, 1);

        // Scenario 6: a set coinciding with a clear leaves sticky at 1.
        src_out = (25'd1 << 7) | (25'd1 << 9);
        step(1);
        expect_rr("rr 7", 7, 1, 8);
        expect_fp("conf set", 7, 1, 1, 1);
        clr_conflict = 1'b1;
        step(1);
        expect_rr("rr 9", 9, 1, 10);
        expect_fp("set wins", 7, 1, 1, 1);
        check("set wins rr sticky", 32'(rr_sticky), 32'd1);
        src_out = '0;
        step(1);
        clr_conflict = 1'b0;
        expect_fp("clr", 0, 0, 0, 0);

`ifdef BUS_SOURCE_ARBITER_CONFLICT_COUNT_EN
        check("count after clr", 32'(fp_count), 32'd0);
        src_out = (25'd1 << 2) | (25'd1 << 11);
        step(10);
        check("count 10", 32'(fp_count), 32'd10);
        step(290);
        check("count sat fp", 32'(fp_count), 32'd255);
        check("count sat rr", 32'(rr_count), 32'd255);
        src_out      = '0;
        clr_conflict = 1'b1;
        step(1);
        clr_conflict = 1'b0;
        check("count clr", 32'(fp_count), 32'd0);
`endif

        // Reset mid-operation aborts the grant without a clock edge.
        src_out = 25'd1 << 5;
        step(1);
        expect_fp("pre rst", 5, 1, 0, 0);
        #2;
        clear = 1'b0;
        #1;
        expect_fp("async rst", 0, 0, 0, 0);
        expect_rr("async rst", 0, 0, 0);
        step(1);
        check("rst held fp valid", 32'(fp_valid), 32'd0);
        // The first edge after clear rises samples src_out normally.
        clear = 1'b1;
        step(1);
        expect_fp("post rst", 5, 1, 0, 0);
        expect_rr("post rst", 5, 1, 6);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
